// File: rtl/adder_arbiter_pkg.sv
// adder_arbiter_pkg: shared sizes and FSM encoding for the arbitrated adder
package adder_arbiter_pkg;
  localparam int NUM_REQ = 4;
  localparam int WIDTH = 64;
  localparam int ID_W = 2;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
endpackage

// File: rtl/adder_arbiter_cla.sv
// cla_64bit: carry-lookahead adder, 4-bit lookahead groups chained by group generate/propagate
module cla_64bit
  import adder_arbiter_pkg::*;
(
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] s_o,
  output logic             overflow_o
);
  logic [WIDTH-1:0] g, p;
  logic [WIDTH:0] c;
  logic [WIDTH/4:0] cg;
  logic [WIDTH/4-1:0] gg, pg;
  always_comb begin
    g = a_i & b_i;
    p = a_i ^ b_i;
    gg = '0;
    pg = '0;
    cg = '0;
    c = '0;
    cg[0] = cin_i;
    for (int k = 0; k < WIDTH/4; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pg[k] = &p[4*k +: 4];
      cg[k+1] = gg[k] | (pg[k] & cg[k]);
      c[4*k] = cg[k];
      for (int j = 0; j < 3; j++)
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
    end
    c[WIDTH] = cg[WIDTH/4];
  end
  assign s_o = p ^ c[WIDTH-1:0];
  // signed overflow: carry into the sign bit differs from carry out of it
  assign overflow_o = c[WIDTH] ^ c[WIDTH-1];
endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter feeding one registered add/sub pipeline slot
module adder_arbiter #(
  parameter int NUM_REQ = adder_arbiter_pkg::NUM_REQ,
  parameter int WIDTH = adder_arbiter_pkg::WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               in_req_valid,
  output logic [NUM_REQ-1:0]               out_req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]         in_a,
  input  logic [NUM_REQ*WIDTH-1:0]         in_b,
  input  logic [NUM_REQ-1:0]               in_sub,
  input  logic [NUM_REQ-1:0]               in_carry,
  output logic                             out_valid,
  input  logic                             in_ready,
  output logic [WIDTH-1:0]                 out_s,
  output logic                             out_overflow,
  output logic [adder_arbiter_pkg::ID_W-1:0] out_id
);
  import adder_arbiter_pkg::*;
  state_t state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d, id_q, gnt_id, cand;
  logic [WIDTH-1:0] a_q, b_q, sum;
  logic cin_q, ovf, gnt_any, slot_free, xfer;
  always_comb begin
    gnt_any = 1'b0;
    gnt_id = '0;
    cand = '0;
    // scan from farthest to nearest so the first valid at/after the pointer wins
    for (int o = NUM_REQ-1; o >= 0; o--) begin
      cand = ptr_q + ID_W'(o);
      if (in_req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_id = cand;
      end
    end
  end
  assign slot_free = (state_q == IDLE) || (state_q == DONE && in_ready);
  assign xfer = slot_free && gnt_any && !rst;
  assign out_req_ready = xfer ? NUM_REQ'(1) << gnt_id : '0;
  assign out_valid = (state_q == DONE);
  always_comb begin
    state_d = xfer ? EXEC
            : (state_q == EXEC) ? DONE
            : (state_q == DONE && in_ready) ? IDLE : state_q;
    ptr_d = xfer ? gnt_id + ID_W'(1) : ptr_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      a_q <= '0;
      b_q <= '0;
      cin_q <= 1'b0;
      id_q <= '0;
      out_s <= '0;
      out_overflow <= 1'b0;
      out_id <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      if (xfer) begin
        a_q <= in_a[gnt_id*WIDTH +: WIDTH];
        b_q <= in_b[gnt_id*WIDTH +: WIDTH] ^ {WIDTH{in_sub[gnt_id]}};
        cin_q <= in_carry[gnt_id] ^ in_sub[gnt_id];
        id_q <= gnt_id;
      end
      if (state_q == EXEC) begin
        out_s <= sum;
        out_overflow <= ovf;
        out_id <= id_q;
      end
    end
  cla_64bit u_cla (
    .a_i(a_q),
    .b_i(b_q),
    .cin_i(cin_q),
    .s_o(sum),
    .overflow_o(ovf)
  );
endmodule
